// File: rtl/mult_wide_pkg.sv
// mult_wide_pkg: shared constants, state type and limb-pair helpers for the
// wide schoolbook multiplier sequencer (mult_wide_seq / mult_wide_acc).
package mult_wide_pkg;

  localparam int unsigned LIMB_W      = 18;  // must match the external multiplier width
  localparam int unsigned LIMBS       = 4;
  localparam int unsigned OP_W        = LIMBS * LIMB_W;
  localparam int unsigned PROD_W      = 2 * OP_W;
  localparam int unsigned NPAIRS      = LIMBS * LIMBS;
  localparam int unsigned FLUSH_PAIRS = 4;   // multiplier pipeline depth in transfers
  localparam int unsigned K_MAX       = NPAIRS + FLUSH_PAIRS;
  localparam int unsigned KW          = $clog2(K_MAX + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Zero-based pair index -> limb of A (row) and limb of B (column).
  function automatic logic [KW-1:0] pair_row(input logic [KW-1:0] idx);
    return idx / KW'(LIMBS);
  endfunction

  function automatic logic [KW-1:0] pair_col(input logic [KW-1:0] idx);
    return idx % KW'(LIMBS);
  endfunction

endpackage

// File: rtl/mult_wide_acc.sv
// mult_wide_acc: shifted-add accumulator for limb partial products.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr_i      - clear accumulator (has priority over add_en_i)
//   add_en_i   - add addend_i << (shift_i*LIMB_W) into the accumulator
//   shift_i    - limb position of the addend (row + column of the pair)
//   addend_i   - 2*LIMB_W-bit partial product
//   sum_o      - accumulator plus shifted addend (combinational), used for the final load
module mult_wide_acc
  import mult_wide_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                add_en_i,
  input  logic [KW-1:0]       shift_i,
  input  logic [2*LIMB_W-1:0] addend_i,
  output logic [PROD_W-1:0]   sum_o
);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] addend_ext;

  always_comb begin
    addend_ext = PROD_W'(addend_i) << (32'(shift_i) * LIMB_W);
    // Partial sums never exceed the final product, so no carry-out is possible.
    sum_o      = acc_q + addend_ext;
    acc_d      = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mult_wide_seq.sv
// mult_wide_seq: computes A*B for two LIMBS*LIMB_W-bit operands by streaming
// schoolbook limb pairs through an external 18x18 AXI-stream multiplier with a
// fixed four-transfer pipeline, then accumulating the shifted partial products.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   s_a_tdata, s_b_tdata, s_tvalid,
//   s_tready                       - operand pair input stream
//   m_tdata, m_tvalid, m_tready    - full-width product output stream
//   mul_a_*, mul_b_*               - limb operands to the multiplier
//   mul_p_tdata, mul_p_tvalid,
//   mul_p_tready                   - multiplier product (capture is counter-driven)
module mult_wide_seq
  import mult_wide_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     s_a_tdata,
  input  logic [OP_W-1:0]     s_b_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [PROD_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [LIMB_W-1:0]   mul_a_tdata,
  output logic                mul_a_tvalid,
  input  logic                mul_a_tready,
  output logic [LIMB_W-1:0]   mul_b_tdata,
  output logic                mul_b_tvalid,
  input  logic                mul_b_tready,
  input  logic [2*LIMB_W-1:0] mul_p_tdata,
  input  logic                mul_p_tvalid,
  output logic                mul_p_tready
);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [PROD_W-1:0] m_tdata_q, m_tdata_d;
  logic              s_tready_q, s_tready_d;

  logic              busy;
  logic              transfer;
  logic [KW-1:0]     iss_idx, ret_idx;
  logic [KW-1:0]     iss_row, iss_col;
  logic [KW-1:0]     ret_shift;
  logic [LIMB_W-1:0] a_limb, b_limb;
  logic              acc_clr, acc_add;
  logic [PROD_W-1:0] acc_sum;

  // Product capture is purely transfer-count driven; the valid flag carries no information.
  logic              unused_p_tvalid;
  assign unused_p_tvalid = mul_p_tvalid;

  assign busy     = (state_q == StBusy);
  assign transfer = busy & mul_a_tready & mul_b_tready;

  // Limb pair being issued (transfer k) and pair whose product returns now (transfer k-4).
  always_comb begin
    iss_idx   = k_q - KW'(1);
    ret_idx   = k_q - KW'(FLUSH_PAIRS + 1);
    iss_row   = pair_row(iss_idx);
    iss_col   = pair_col(iss_idx);
    ret_shift = pair_row(ret_idx) + pair_col(ret_idx);
    a_limb    = '0;
    b_limb    = '0;
    for (int unsigned r = 0; r < LIMBS; r++) begin
      if (iss_row == KW'(r)) a_limb = a_q[r*LIMB_W +: LIMB_W];
      if (iss_col == KW'(r)) b_limb = b_q[r*LIMB_W +: LIMB_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    m_tdata_d = m_tdata_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_tvalid && s_tready_q) begin
          a_d     = s_a_tdata;
          b_d     = s_b_tdata;
          k_d     = KW'(1);
          acc_clr = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (transfer) begin
          k_d = k_q + KW'(1);
          // The first four samples are left over from whatever was in the pipeline.
          if (k_q >= KW'(FLUSH_PAIRS + 1)) acc_add = 1'b1;
          if (k_q == KW'(K_MAX)) begin
            m_tdata_d = acc_sum;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        if (m_tready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered so that s_tready sits at 0 during and right after reset.
    s_tready_d = (state_d == StIdle);
  end

  mult_wide_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr),
    .add_en_i (acc_add),
    .shift_i  (ret_shift),
    .addend_i (mul_p_tdata),
    .sum_o    (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_tdata_q  <= '0;
      s_tready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m_tdata_q  <= m_tdata_d;
      s_tready_q <= s_tready_d;
    end
  end

  // Flush transfers (k > NPAIRS) push zeros through the multiplier.
  assign mul_a_tdata  = (busy && (k_q <= KW'(NPAIRS))) ? a_limb : '0;
  assign mul_b_tdata  = (busy && (k_q <= KW'(NPAIRS))) ? b_limb : '0;
  assign mul_a_tvalid = busy;
  assign mul_b_tvalid = busy;
  assign mul_p_tready = busy;
  assign s_tready     = s_tready_q;
  assign m_tvalid     = (state_q == StDone);
  assign m_tdata      = m_tdata_q;

endmodule

// File: tb/tb_mult_wide_seq.sv
// Self-checking bench for mult_wide_seq with a behavioural 4-stage mult_36 model.
module tb_mult_wide_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [71:0]  s_a_tdata, s_b_tdata;
  logic         s_tvalid, s_tready;
  logic [143:0] m_tdata;
  logic         m_tvalid, m_tready;
  logic [17:0]  mul_a_tdata, mul_b_tdata;
  logic         mul_a_tvalid, mul_b_tvalid, mul_a_tready, mul_b_tready;
  logic [35:0]  mul_p_tdata;
  logic         mul_p_tvalid, mul_p_tready;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mult_wide_seq dut (
    .clk          (clk),
    .rst          (rst),
    .s_a_tdata    (s_a_tdata),
    .s_b_tdata    (s_b_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .mul_a_tdata  (mul_a_tdata),
    .mul_a_tvalid (mul_a_tvalid),
    .mul_a_tready (mul_a_tready),
    .mul_b_tdata  (mul_b_tdata),
    .mul_b_tvalid (mul_b_tvalid),
    .mul_b_tready (mul_b_tready),
    .mul_p_tdata  (mul_p_tdata),
    .mul_p_tvalid (mul_p_tvalid),
    .mul_p_tready (mul_p_tready)
  );

  // Multiplier model: product of a transfer appears four transfers later.
  logic [35:0] pipe [4];
  assign mul_p_tdata  = pipe[3];
  assign mul_p_tvalid = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else if (mul_a_tvalid && mul_b_tvalid && mul_a_tready && mul_b_tready) begin
      pipe[0] <= 36'(mul_a_tdata) * 36'(mul_b_tdata);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
  end

  function automatic logic [71:0] rand72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  function automatic logic [143:0] ref_mul(input logic [71:0] a, input logic [71:0] b);
    return {72'd0, a} * {72'd0, b};
  endfunction

  // Submit one operand pair and wait (bounded) for m_tvalid; returns at the
  // negedge of the first DONE cycle with the cycle count since accept.
  task automatic run_op(input logic [71:0] a, input logic [71:0] b, input int stall_len,
                        output logic [143:0] prod, output int lat);
    int xfers, stalled, n;
    xfers = 0; stalled = 0; n = 0;
    s_a_tdata = a;
    s_b_tdata = b;
    s_tvalid  = 1'b1;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmp_cnt++;
    if (s_tready !== 1'b1) begin
      err_cnt++;
      $display("FAIL accept_timeout: s_tready=%b required 1", s_tready);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    lat = 1;
    while (!m_tvalid && lat < 200) begin
      if (stall_len > 0 && xfers == 6 && stalled < stall_len) begin
        mul_a_tready = 1'b0;
        stalled++;
      end else begin
        mul_a_tready = 1'b1;
      end
      if (mul_a_tvalid && mul_a_tready && mul_b_tready) xfers++;
      @(negedge clk);
      lat++;
    end
    mul_a_tready = 1'b1;
    prod = m_tdata;
  endtask

  task automatic take_result();
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({s_tready, m_tvalid, mul_a_tvalid, mul_b_tvalid, mul_p_tready} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {s_tready, m_tvalid, mul_a_tvalid, mul_b_tvalid, mul_p_tready});
    end
    cmp_cnt++;
    if ({m_tdata, mul_a_tdata, mul_b_tdata} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: m=%h a=%h b=%h required 0", m_tdata, mul_a_tdata, mul_b_tdata);
    end
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (s_tready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_ready: got %b required 1", s_tready);
    end
  endtask

  task automatic test_directed();
    logic [71:0]  a_t [3];
    logic [71:0]  b_t [3];
    logic [143:0] e_t [3];
    logic [143:0] got;
    int lat;
    a_t[0] = 72'h0;      b_t[0] = 72'h12_3456_789A_BCDE_F012; e_t[0] = 144'h0;
    a_t[1] = 72'h40000;  b_t[1] = 72'h3;                      e_t[1] = 144'hC0000;
    a_t[2] = '1;         b_t[2] = '1;
    e_t[2] = {72'hFF_FFFF_FFFF_FFFF_FFFE, 72'h1};
    for (int t = 0; t < 3; t++) begin
      run_op(a_t[t], b_t[t], 0, got, lat);
      cmp_cnt++;
      if (got !== e_t[t]) begin
        err_cnt++;
        $display("FAIL directed_%0d_product: got %h required %h", t, got, e_t[t]);
      end
      cmp_cnt++;
      if (lat != 21) begin
        err_cnt++;
        $display("FAIL directed_%0d_latency: got %0d required 21", t, lat);
      end
      take_result();
      cmp_cnt++;
      if ({m_tvalid, s_tready} !== 2'b01) begin
        err_cnt++;
        $display("FAIL directed_%0d_handshake: m_tvalid,s_tready=%b required 01",
                 t, {m_tvalid, s_tready});
      end
    end
  endtask

  task automatic test_random();
    logic [71:0]  a, b;
    logic [143:0] got;
    int lat;
    for (int t = 0; t < 6; t++) begin
      a = rand72();
      b = rand72();
      if (t == 0) a[71:54] = '0;  // one op with a zero top limb
      run_op(a, b, 0, got, lat);
      cmp_cnt++;
      if (got !== ref_mul(a, b)) begin
        err_cnt++;
        $display("FAIL random_%0d_product: got %h required %h", t, got, ref_mul(a, b));
      end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    logic [71:0]  a, b;
    logic [143:0] got, held;
    int lat;
    a = rand72();
    b = rand72();
    run_op(a, b, 0, got, lat);
    cmp_cnt++;
    if (got !== ref_mul(a, b)) begin
      err_cnt++;
      $display("FAIL b2b_first_product: got %h required %h", got, ref_mul(a, b));
    end
    held = ref_mul(a, b);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({m_tvalid, s_tready, m_tdata} !== {1'b1, 1'b0, held}) begin
        err_cnt++;
        $display("FAIL b2b_hold_%0d: m_tvalid=%b s_tready=%b m_tdata=%h required 1 0 %h",
                 c, m_tvalid, s_tready, m_tdata, held);
      end
    end
    take_result();
    run_op(72'd1, 72'd5, 0, got, lat);
    cmp_cnt++;
    if (got !== 144'd5) begin
      err_cnt++;
      $display("FAIL b2b_second_product: got %h required 5", got);
    end
    take_result();
  endtask

  task automatic test_stall();
    logic [71:0]  a, b;
    logic [143:0] got;
    int lat;
    a = rand72();
    b = rand72();
    run_op(a, b, 3, got, lat);
    cmp_cnt++;
    if (got !== ref_mul(a, b)) begin
      err_cnt++;
      $display("FAIL stall_product: got %h required %h", got, ref_mul(a, b));
    end
    cmp_cnt++;
    if (lat != 24) begin
      err_cnt++;
      $display("FAIL stall_latency: got %0d required 24", lat);
    end
    take_result();
  endtask

  task automatic test_mid_reset();
    logic [143:0] got;
    int lat, n;
    n = 0;
    s_a_tdata = rand72();
    s_b_tdata = rand72();
    s_tvalid  = 1'b1;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);            // BUSY cycle 1
    s_tvalid = 1'b0;
    repeat (9) @(negedge clk); // BUSY cycle 10
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp_cnt++;
    if ({s_tready, m_tvalid, mul_a_tvalid, mul_b_tvalid, mul_p_tready} !== 5'b0) begin
      err_cnt++;
      $display("FAIL midrst_ctrl: got %b required 00000",
               {s_tready, m_tvalid, mul_a_tvalid, mul_b_tvalid, mul_p_tready});
    end
    cmp_cnt++;
    if ({m_tdata, mul_a_tdata, mul_b_tdata} !== '0) begin
      err_cnt++;
      $display("FAIL midrst_data: m=%h a=%h b=%h required 0", m_tdata, mul_a_tdata, mul_b_tdata);
    end
    run_op(72'd7, 72'd9, 0, got, lat);
    cmp_cnt++;
    if (got !== 144'd63) begin
      err_cnt++;
      $display("FAIL midrst_next_product: got %h required 63", got);
    end
    cmp_cnt++;
    if (lat != 21) begin
      err_cnt++;
      $display("FAIL midrst_next_latency: got %0d required 21", lat);
    end
    take_result();
  endtask

  initial begin
    rst          = 1'b1;
    s_a_tdata    = '0;
    s_b_tdata    = '0;
    s_tvalid     = 1'b0;
    m_tready     = 1'b0;
    mul_a_tready = 1'b1;
    mul_b_tready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mult_wide_seq.md
# mult_wide_seq

Sequencer that computes a full-width product of two multi-limb operands by driving the team's 18x18 AXI-stream multiplier (mult_36) with schoolbook limb pairs and accumulating the 36-bit partial products. Sits between the ElGamal modular-arithmetic stages and the shared multiplier port. It owns the multiplier for the duration of one operation and returns a 2*LIMBS*LIMB_W-bit product over an AXI-stream output.

## Interface
- LIMB_W, 18, limb width; must equal the multiplier operand width.
- LIMBS, 4, limbs per operand; operand width is LIMBS*LIMB_W (72 by default).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_a_tdata  in  LIMBS*LIMB_W  operand A; limb i is bits [i*LIMB_W +: LIMB_W].
- s_b_tdata  in  LIMBS*LIMB_W  operand B; same limb layout.
- s_tvalid  in  1  operand pair valid.
- s_tready  out  1  operand pair accepted; reset value 0.
- m_tdata  out  2*LIMBS*LIMB_W  product A*B; reset value 0.
- m_tvalid  out  1  product valid; reset value 0.
- m_tready  in  1  downstream accepts product.
- mul_a_tdata, mul_b_tdata  out  LIMB_W  limb operands to multiplier; reset value 0.
- mul_a_tvalid, mul_b_tvalid  out  1  reset value 0.
- mul_a_tready, mul_b_tready  in  1  from multiplier.
- mul_p_tdata  in  2*LIMB_W  multiplier product.
- mul_p_tvalid  in  1  unused for capture; capture is counter-driven.
- mul_p_tready  out  1  reset value 0.

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE, pair counter 0, accumulator 0.
- IDLE: s_tready=1. On s_tvalid&s_tready, latch A and B, clear accumulator and counter, go to BUSY.
- BUSY: mul_a_tvalid=mul_b_tvalid=mul_p_tready=1. A transfer is mul_a_tvalid&mul_a_tready&mul_b_tready; the counter k (1..NPAIRS+4, NPAIRS=LIMBS*LIMBS) advances only on a transfer.
- Issue order for k<=NPAIRS: i=(k-1)/LIMBS, j=(k-1)%LIMBS; drive a_i, b_j. For k>NPAIRS (4 flush pairs) drive zeros.
- Multiplier contract: the product of transfer k is on mul_p_tdata during the cycle that presents transfer k+4. When k>=5 and a transfer occurs, add mul_p_tdata << ((i'+j')*LIMB_W) to the accumulator, where (i',j') is the limb pair of transfer k-4. Samples for k<=4 are discarded (stale data from the previous operation).
- On the transfer with k=NPAIRS+4: perform the final accumulate, load m_tdata, go to DONE.
- DONE: m_tvalid=1 and m_tdata held stable until m_tready. On m_tvalid&m_tready, go to IDLE.
- Arithmetic: the accumulator is 2*LIMBS*LIMB_W bits, unsigned. Intermediate sums are bounded by the final product, so there is no overflow and no carry-out.
- Reset mid-operation (any state): return to IDLE with all outputs at reset values. The multiplier shares rst, so its pipeline is also cleared. No partial result is emitted.
- s_tvalid during BUSY/DONE is ignored (s_tready=0). m_tready while not DONE has no effect.

## Timing
- Accept edge E0. With the multiplier never stalling, BUSY spans cycles 1..NPAIRS+4 (20 by default), one transfer per cycle.
- m_tvalid rises in cycle NPAIRS+5 (21). s_tready rises in the cycle after the m handshake.
- Minimum operation period: NPAIRS+6 cycles (22).
- A multiplier stall (tready low) freezes the counter and accumulator; the operands stay stable until the transfer completes.
- Outputs are registered; there is no combinational path from s_* to m_* or from mul_p_* to any output.

## Structure
- Package mult_wide_pkg: LIMB_W, LIMBS, NPAIRS, FLUSH_PAIRS=4, state enum {IDLE,BUSY,DONE}.
- One sub-module: mult_wide_acc. It is the shifted-add accumulator (clear, add-enable, shift index, 36-bit addend).
- The multiplier is external, so a future arbiter can share it. The top level connects mult_wide_seq to mult_36.

## Test plan
- A=0, B=0x12_3456_789A_BCDE_F012 -> m_tdata=0; m_tvalid exactly 21 cycles after accept.
- A=0x40000 (limb1=1), B=3 -> m_tdata=0xC0000.
- A=B=2^72-1 -> m_tdata upper 72 bits 0xFF_FFFF_FFFF_FFFF_FFFE, lower 72 bits 0x1.
- Back-to-back: random A,B followed by A=1,B=5 with no reset -> second result exactly 5, confirming stale pipeline data is discarded. m_tready held low 5 cycles -> m_tdata stable and s_tready=0 throughout.
- Multiplier model drops mul_a_tready for 3 cycles at k=7 -> correct random product, latency +3.
- rst asserted in cycle 10 of BUSY -> all outputs 0 the next cycle; a following op A=7,B=9 yields 63.
